esm_buffer_ctrl: RTL and testbench
==================================

Name: esm_buffer_ctrl

Overview:
- Owns the bs-entry instruction buffer that feeds the ESM dependency core.
- Accepts instructions from fetch and writes each into the lowest free slot. Presents every newly written slot to the core as Instr_in/buffer_index, and publishes valid_entries.
- Uses the core's scheduling result (next_buffer_index, valid_count) to issue one instruction at a time downstream over a valid/ready handshake, then retires that slot.

Parameters:
- Instruction_word_size, 32, instruction width in bits.
- bs, 16, buffer depth; power of two, at least 2.
- IW, $clog2(bs), slot index width (derived, not overridable).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops all buffered entries.
- in_valid  input  1  fetch offers an instruction.
- in_instr  input  Instruction_word_size  fetched instruction.
- in_ready  output  1  buffer can accept an instruction.
- core_instr  output  Instruction_word_size  driven to the core's Instr_in.
- buffer_index  output  IW  slot holding core_instr.
- core_strobe  output  1  core_instr/buffer_index are new this cycle.
- valid_entries  output  [0:bs-1]  bit i = slot i occupied.
- sched_index  input  IW  core's next_buffer_index.
- sched_valid  input  1  core's valid_count.
- issue_valid  output  1  issue_instr is offered downstream.
- issue_instr  output  Instruction_word_size  instruction being issued.
- issue_index  output  IW  slot being issued.
- issue_ready  input  1  downstream accepts.
- occupancy  output  IW+1  number of set bits in valid_entries.
- full  output  1  all slots valid.
- empty  output  1  no slot valid.

Behaviour:
- Reset values: valid_entries=0, occupancy=0, empty=1, full=0, core_strobe=0, issue_valid=0, buffer_index=0, issue_index=0, core_instr=0, issue_instr=0, FSM=S_IDLE. Buffer storage contents are not reset.
- Priority: rst > flush > normal operation.

Accept path:
- in_ready = ~full & ~flush (combinational).
- Accept fires when in_valid & in_ready. The instruction is written to the lowest-index free slot f, computed from the current-cycle valid_entries.
- Cycle after accept: valid_entries[f]=1, core_instr=in_instr, buffer_index=f, core_strobe=1 for exactly one cycle.
- core_instr and buffer_index hold their last value while core_strobe=0.

Issue FSM:
- States: S_IDLE, S_ISSUE, S_SETTLE.
- S_IDLE: if sched_valid & valid_entries[sched_index], latch idx=sched_index and go to S_ISSUE. A sched_valid that points at an invalid slot is ignored.
- S_ISSUE: issue_valid=1, issue_index=idx, issue_instr=buf[idx]. All three stay stable until handshake. On issue_ready: clear valid_entries[idx] next cycle and go to S_SETTLE.
- S_SETTLE: one cycle, issue_valid=0, lets the registered scheduler see the updated vector. Then go to S_IDLE.
- Issue latency is 1 cycle from a qualifying sched_valid to issue_valid; best-case throughput is 1 issue per 3 cycles.

Simultaneous events:
- Accept and retire in the same cycle: both apply. The retired slot is not reusable until the following cycle, because f is computed from the pre-retire vector. occupancy is unchanged.
- Accept while full: impossible (in_ready=0). Retire while full: in_ready rises the next cycle.
- flush: next cycle valid_entries=0, FSM=S_IDLE, issue_valid=0, core_strobe=0. An in-flight issue_ready in the flush cycle is ignored (no issue).
- occupancy, full and empty are registered and consistent with valid_entries in the same cycle.

Decomposition:
- Package esm_pkg: FSM state typedef (S_IDLE=2'd0, S_ISSUE=2'd1, S_SETTLE=2'd2), index-width function, and the [0:bs-1] bit-ordering convention shared with the core.
- Sub-module esm_free_slot_enc: combinational lowest-zero priority encoder over valid_entries, producing index plus found flag.
- Storage array, valid vector and FSM stay in the top.

Test Plan:
- Reset → rst high 2 cycles then low: valid_entries=0, empty=1, in_ready=1, issue_valid=0, occupancy=0.
- Fill → 16 back-to-back accepts of 0x100+i: slots 0..15 written in order, core_strobe each cycle with buffer_index=i, full=1 after the 16th, in_ready=0, occupancy=16.
- Issue with backpressure → slots 0..3 valid, sched_index=2, sched_valid=1, issue_ready low 3 cycles then high: issue_valid next cycle, issue_index=2, issue_instr stable for 4 cycles, then valid_entries bit2 cleared, S_SETTLE one cycle, occupancy 4→3.
- Invalid schedule → sched_index=7 with slot 7 empty, sched_valid=1: FSM stays S_IDLE, issue_valid=0.
- Accept + retire same cycle → full buffer, retire slot 5 while in_valid high: in_ready=0 that cycle, in_ready=1 next cycle, following accept lands in slot 5.
- Flush mid-issue → in S_ISSUE with issue_ready=1 and flush=1: issue_valid=0 next cycle, valid_entries=0, occupancy=0, empty=1, no retire counted.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM instruction buffer and its dependency core.
// Slot vectors are declared [0:bs-1] so that bit i always names slot i on both sides.
package esm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } esm_state_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/esm_free_slot_enc.sv
// Lowest-zero priority encoder over the slot valid vector.
module esm_free_slot_enc
    import esm_pkg::*;
#(
    parameter int unsigned bs = 16,
    parameter int unsigned IW = idx_width(bs)
) (
    input  logic [0:bs-1]   valid_entries,
    output logic [IW-1:0]   index,
    output logic            found
);

    // Scan from the top down so the last hit is the lowest free slot.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid_entries[i]) begin
                index = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esm_buffer_ctrl.sv
// Instruction buffer in front of the ESM dependency core: fills the lowest free slot from
// fetch, reports each write to the core and issues the core's chosen slot downstream.
module esm_buffer_ctrl
    import esm_pkg::*;
#(
    parameter int unsigned Instruction_word_size = 32,
    parameter int unsigned bs = 16,
    localparam int unsigned IW = idx_width(bs)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [Instruction_word_size-1:0] in_instr,
    output logic                             in_ready,
    output logic [Instruction_word_size-1:0] core_instr,
    output logic [IW-1:0]                    buffer_index,
    output logic                             core_strobe,
    output logic [0:bs-1]                    valid_entries,
    input  logic [IW-1:0]                    sched_index,
    input  logic                             sched_valid,
    output logic                             issue_valid,
    output logic [Instruction_word_size-1:0] issue_instr,
    output logic [IW-1:0]                    issue_index,
    input  logic                             issue_ready,
    output logic [IW:0]                      occupancy,
    output logic                             full,
    output logic                             empty
);

    logic [Instruction_word_size-1:0] buf_mem [bs];
    logic [0:bs-1]                    valid_d;
    logic [IW:0]                      occ_d;
    logic [IW-1:0]                    free_idx;
    logic                             free_found;
    logic                             accept;
    logic                             retire;
    esm_state_e                       state;

    esm_free_slot_enc #(
        .bs (bs),
        .IW (IW)
    ) u_free_slot_enc (
        .valid_entries (valid_entries),
        .index         (free_idx),
        .found         (free_found)
    );

    assign in_ready = ~full & ~flush;
    assign accept   = in_valid & in_ready & free_found;
    assign retire   = (state == S_ISSUE) & issue_ready & ~flush;

    // The free slot comes from the pre-retire vector, so a retiring slot is never refilled
    // in the same cycle.
    always_comb begin
        valid_d = valid_entries;
        if (retire) valid_d[issue_index] = 1'b0;
        if (accept) valid_d[free_idx] = 1'b1;
        occ_d = '0;
        for (int i = 0; i < bs; i++) begin
            occ_d = occ_d + {{IW{1'b0}}, valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buf_mem[free_idx] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_entries <= '0;
            occupancy     <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            core_strobe   <= 1'b0;
            core_instr    <= '0;
            buffer_index  <= '0;
            issue_valid   <= 1'b0;
            issue_index   <= '0;
            issue_instr   <= '0;
            state         <= S_IDLE;
        end else if (flush) begin
            valid_entries <= '0;
            occupancy     <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            core_strobe   <= 1'b0;
            issue_valid   <= 1'b0;
            state         <= S_IDLE;
        end else begin
            valid_entries <= valid_d;
            occupancy     <= occ_d;
            full          <= &valid_d;
            empty         <= ~|valid_d;
            core_strobe   <= accept;
            if (accept) begin
                core_instr   <= in_instr;
                buffer_index <= free_idx;
            end
            unique case (state)
                S_IDLE: begin
                    if (sched_valid && valid_entries[sched_index]) begin
                        issue_valid <= 1'b1;
                        issue_index <= sched_index;
                        issue_instr <= buf_mem[sched_index];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        state       <= S_SETTLE;
                    end
                end
                // One dead cycle so the registered scheduler sees the retired slot.
                S_SETTLE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esm_buffer_ctrl.sv
// Scoreboard bench for esm_buffer_ctrl: a slot-level reference model predicts writes and
// issues; a negedge monitor checks every cycle against it.
module tb_esm_buffer_ctrl;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_instr;
    logic          in_ready;
    logic [W-1:0]  core_instr;
    logic [IW-1:0] buffer_index;
    logic          core_strobe;
    logic [0:BS-1] valid_entries;
    logic [IW-1:0] sched_index;
    logic          sched_valid;
    logic          issue_valid;
    logic [W-1:0]  issue_instr;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic [IW:0]   occupancy;
    logic          full;
    logic          empty;

    esm_buffer_ctrl #(
        .Instruction_word_size (W),
        .bs                    (BS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .core_instr    (core_instr),
        .buffer_index  (buffer_index),
        .core_strobe   (core_strobe),
        .valid_entries (valid_entries),
        .sched_index   (sched_index),
        .sched_valid   (sched_valid),
        .issue_valid   (issue_valid),
        .issue_instr   (issue_instr),
        .issue_index   (issue_index),
        .issue_ready   (issue_ready),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  instr;
    } exp_t;

    int       n_tests = 0;
    int       n_fail  = 0;
    bit       armed   = 1'b0;
    bit       mv [BS];
    logic [W-1:0] mmem [BS];
    bit       m_issuing;
    bit       m_settle;
    int       m_idx;
    exp_t     strobe_q [$];
    exp_t     issue_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < BS; i++) mv[i] = 1'b0;
        m_issuing = 1'b0;
        m_settle  = 1'b0;
        m_idx     = 0;
        issue_q.delete();
    endtask

    // Applied right after a clock edge, using the inputs that were held across that edge.
    task automatic model_update();
        int   cnt;
        int   f;
        exp_t e;
        if (flush) begin
            model_clear();
            return;
        end
        cnt = 0;
        f   = -1;
        for (int i = 0; i < BS; i++) begin
            cnt += int'(mv[i]);
            if (!mv[i] && f < 0) f = i;
        end
        if (m_issuing) begin
            if (issue_ready) begin
                mv[m_idx] = 1'b0;
                m_issuing = 1'b0;
                m_settle  = 1'b1;
                void'(issue_q.pop_front());
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (sched_valid && mv[sched_index]) begin
            m_issuing = 1'b1;
            m_idx     = int'(sched_index);
            e.idx     = sched_index;
            e.instr   = mmem[sched_index];
            issue_q.push_back(e);
        end
        if (in_valid && cnt < BS) begin
            mv[f]   = 1'b1;
            mmem[f] = in_instr;
            e.idx   = IW'(f);
            e.instr = in_instr;
            strobe_q.push_back(e);
        end
    endtask

    task automatic step(input bit iv, input logic [W-1:0] ins, input bit sv,
                        input logic [IW-1:0] sidx, input bit ir, input bit fl);
        in_valid    = iv;
        in_instr    = ins;
        sched_valid = sv;
        sched_index = sidx;
        issue_ready = ir;
        flush       = fl;
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [0:BS-1] ev;
        int            cnt;
        exp_t          e;
        if (armed) begin
            cnt = 0;
            for (int i = 0; i < BS; i++) begin
                ev[i] = mv[i];
                cnt  += int'(mv[i]);
            end
            check("valid_entries", 64'(valid_entries), 64'(ev));
            check("occupancy", 64'(occupancy), 64'(cnt));
            check("full", 64'(full), 64'(cnt == BS));
            check("empty", 64'(empty), 64'(cnt == 0));
            check("in_ready", 64'(in_ready), 64'(cnt != BS && !flush));
            check("issue_valid", 64'(issue_valid), 64'(m_issuing));
            if (issue_valid) begin
                if (issue_q.size() == 0) begin
                    check("issue_unexpected", 64'(issue_valid), 64'(0));
                end else begin
                    check("issue_index", 64'(issue_index), 64'(issue_q[0].idx));
                    check("issue_instr", 64'(issue_instr), 64'(issue_q[0].instr));
                end
            end
            if (core_strobe) begin
                if (strobe_q.size() == 0) begin
                    check("strobe_unexpected", 64'(core_strobe), 64'(0));
                end else begin
                    e = strobe_q.pop_front();
                    check("buffer_index", 64'(buffer_index), 64'(e.idx));
                    check("core_instr", 64'(core_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        sched_valid = 1'b0;
        sched_index = '0;
        issue_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_core_strobe", 64'(core_strobe), 64'(0));
        check("rst_core_instr", 64'(core_instr), 64'(0));
        check("rst_buffer_index", 64'(buffer_index), 64'(0));
        check("rst_issue_index", 64'(issue_index), 64'(0));
        check("rst_issue_instr", 64'(issue_instr), 64'(0));
        armed = 1'b1;

        // Fill with 0x100+i, then one offer while full.
        for (int i = 0; i < BS; i++) step(1'b1, W'(32'h100 + i), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD, 1'b0, '0, 1'b0, 1'b0);

        // Issue slot 2 with three cycles of backpressure.
        step(1'b0, '0, 1'b1, 4'd2, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h200, 1'b0, '0, 1'b0, 1'b0);

        // Retire slot 5 while full and offering; the next accept must land in slot 5.
        step(1'b0, '0, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 32'h305, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h305, 1'b0, '0, 1'b0, 1'b0);
        check("refill_slot5", 64'(buffer_index), 64'(5));

        // Flush while a handshake is offered.
        step(1'b0, '0, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Schedule pointing at an empty slot.
        step(1'b1, 32'h400, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        for (int c = 0; c < 1200; c++) begin
            int pv;
            pv = (c < 600) ? 70 : 30;
            step($urandom_range(99) < pv, $urandom, $urandom_range(99) < 60,
                 IW'($urandom_range(BS - 1)), $urandom_range(99) < 50,
                 $urandom_range(63) == 0);
        end

        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("strobe_q_drained", 64'(strobe_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
